// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, WIDTH cycles per operation.
// Optional subtraction is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              y_bit, sum_bit, carry_out, last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    logic              sub_q, sub_d;
`else
    logic              unused_sub;
    assign unused_sub = Sub;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
        // Subtraction consumes ~Y; the forced carry-in supplies the +1.
        y_bit   = y_q[0] ^ sub_q;
`else
        y_bit   = y_q[0];
`endif
        sum_bit   = x_q[0] ^ y_bit ^ carry_q;
        carry_out = (x_q[0] & y_bit) | (carry_q & (x_q[0] ^ y_bit));
        last_bit  = (cnt_q == CntW'(WIDTH - 1));

        unique case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    state_d = StRun;
                    x_d     = X;
                    y_d     = Y;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = Sub;
                    carry_d = Sub ? 1'b1 : Cin;
`else
                    carry_d = Cin;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                x_d     = x_q >> 1;
                y_d     = y_q >> 1;
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                carry_d = carry_out;
                if (last_bit) begin
                    state_d = StDone;
                    s_d     = {sum_bit, res_q[WIDTH-1:1]};
                    cout_d  = carry_out;
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ carry_out;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign Busy = (state_q == StRun);
    assign Done = (state_q == StDone);
    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); expected values are hand-computed.
// Subtract expectations follow SERIAL_ADDER_SUB_EN as defined for the build.
module tb_serial_adder;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] X = '0;
    logic [7:0] Y = '0;
    logic       Cin = 1'b0;
    logic       Sub = 1'b0;
    logic       Busy, Done, Cout, Ovf;
    logic [7:0] S;

    int n_compared = 0;
    int n_mismatched = 0;

    serial_adder #(.WIDTH(8)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .X     (X),
        .Y     (Y),
        .Cin   (Cin),
        .Sub   (Sub),
        .Busy  (Busy),
        .Done  (Done),
        .S     (S),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive Start for one edge, then leave the bench 1 time unit past the accepting edge.
    task automatic drive_start(input logic [7:0] x, input logic [7:0] y, input logic c,
                               input logic sb);
        Start = 1'b1;
        X     = x;
        Y     = y;
        Cin   = c;
        Sub   = sb;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    // lat counts edges from the accepting edge (inclusive) until Done is seen.
    task automatic wait_done(input int start_lat, output int lat);
        lat = start_lat;
        while (!Done && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
        end
    endtask

    int lat;
    int done_seen;

    initial begin
        // Reset state
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_s",    32'(S),    32'h00);
        check("rst_cout", 32'(Cout), 32'd0);
        check("rst_ovf",  32'(Ovf),  32'd0);
        Rst = 1'b0;
        @(posedge Clk);
        #1;

        // 0x0F + 0x01
        drive_start(8'h0F, 8'h01, 1'b0, 1'b0);
        check("a_busy", 32'(Busy), 32'd1);
        wait_done(1, lat);
        check("a_lat",  32'(lat),  32'd9);
        check("a_s",    32'(S),    32'h10);
        check("a_cout", 32'(Cout), 32'd0);
        check("a_ovf",  32'(Ovf),  32'd0);
        check("a_busy_done", 32'(Busy), 32'd0);
        @(posedge Clk);
        #1;
        check("a_done_width", 32'(Done), 32'd0);
        check("a_idle_busy",  32'(Busy), 32'd0);

        // 0xFF + 0x01 + 1
        drive_start(8'hFF, 8'h01, 1'b1, 1'b0);
        wait_done(1, lat);
        check("b_lat",  32'(lat),  32'd9);
        check("b_s",    32'(S),    32'h01);
        check("b_cout", 32'(Cout), 32'd1);
        check("b_ovf",  32'(Ovf),  32'd0);
        @(posedge Clk);
        #1;

        // 0x7F + 0x01 signed overflow
        drive_start(8'h7F, 8'h01, 1'b0, 1'b0);
        check("c_s_hold", 32'(S), 32'h01);
        wait_done(1, lat);
        check("c_s",    32'(S),    32'h80);
        check("c_cout", 32'(Cout), 32'd0);
        check("c_ovf",  32'(Ovf),  32'd1);
        @(posedge Clk);
        #1;

        // Start during RUN is ignored
        drive_start(8'h03, 8'h04, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        Start = 1'b1;
        X     = 8'hAA;
        Y     = 8'h55;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        check("d_s_hold_run", 32'(S), 32'h80);
        wait_done(3, lat);
        check("d_lat", 32'(lat), 32'd9);
        check("d_s",   32'(S),   32'h07);

        // Back-to-back start in the Done cycle
        drive_start(8'h10, 8'h20, 1'b0, 1'b0);
        check("e_busy_next", 32'(Busy), 32'd1);
        check("e_done_next", 32'(Done), 32'd0);
        check("e_s_hold",    32'(S),    32'h07);
        wait_done(1, lat);
        check("e_lat", 32'(lat), 32'd9);
        check("e_s",   32'(S),   32'h30);
        @(posedge Clk);
        #1;

        // Reset asserted in the 4th RUN cycle aborts the operation
        drive_start(8'h11, 8'h22, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("f_busy", 32'(Busy), 32'd0);
        check("f_done", 32'(Done), 32'd0);
        check("f_s",    32'(S),    32'h00);
        done_seen = 0;
        repeat (15) begin
            @(posedge Clk);
            #1;
            if (Done || Busy) done_seen++;
        end
        check("f_no_done", 32'(done_seen), 32'd0);

        // Sub request: honoured only when subtraction is built in
        drive_start(8'h05, 8'h07, 1'b0, 1'b1);
        wait_done(1, lat);
        check("g_lat", 32'(lat), 32'd9);
`ifdef SERIAL_ADDER_SUB_EN
        check("g_s",    32'(S),    32'hFE);
`else
        check("g_s",    32'(S),    32'h0C);
`endif
        check("g_cout", 32'(Cout), 32'd0);
        check("g_ovf",  32'(Ovf),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
